// File: rtl/timer_sequencer.sv
// Egg-timer sequencer: turns button edges and a 1 Hz tick into enable, direction
// and load controls for four cascaded BCD digit counters forming an MM:SS display.
module timer_sequencer #(
   parameter int ALARM_TICKS  = 10,
   parameter int SEC_TENS_MAX = 5,
   parameter int MIN_TENS_MAX = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick_1hz,
   input  logic        start_btn,
   input  logic        pause_btn,
   input  logic        clear_btn,
   input  logic        mode,
   input  logic [15:0] digits,
   output logic [3:0]  digit_en,
   output logic        digit_dir,
   output logic        digit_load,
   output logic        alarm,
   output logic        running,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [3:0]  SEC_MAX  = 4'(SEC_TENS_MAX);
   localparam logic [3:0]  MIN_MAX  = 4'(MIN_TENS_MAX);
   localparam logic [15:0] ALL_MAX  = {MIN_MAX, 4'd9, SEC_MAX, 4'd9};
   localparam logic [7:0]  LAST_CNT = 8'(ALARM_TICKS - 1);

   state_t     state_q, state_n;
   logic       mode_q, mode_n;
   logic [7:0] alarm_cnt, alarm_cnt_n;
   logic       load_n;
   logic       acted;
   logic       start_prev, pause_prev, clear_prev;
   logic       start_rise, pause_rise, clear_rise;
   logic       all_zero, all_max, end_hit;
   logic [2:0] low_ok;

   assign start_rise = start_btn & ~start_prev;
   assign pause_rise = pause_btn & ~pause_prev;
   assign clear_rise = clear_btn & ~clear_prev;

   assign all_zero = (digits == 16'h0000);
   assign all_max  = (digits == ALL_MAX);
   assign end_hit  = (state_q == ST_RUN) && (mode_q ? all_max : all_zero);

   assign state     = state_q;
   assign digit_dir = mode_q;

   // Previous-value registers reset high so a button held through reset is no event.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         start_prev <= 1'b1;
         pause_prev <= 1'b1;
         clear_prev <= 1'b1;
         state_q    <= ST_IDLE;
         mode_q     <= 1'b0;
         alarm_cnt  <= 8'd0;
         digit_load <= 1'b0;
         alarm      <= 1'b0;
         running    <= 1'b0;
      end else begin
         start_prev <= start_btn;
         pause_prev <= pause_btn;
         clear_prev <= clear_btn;
         state_q    <= state_n;
         mode_q     <= mode_n;
         alarm_cnt  <= alarm_cnt_n;
         digit_load <= load_n;
         alarm      <= (state_n == ST_DONE);
         running    <= (state_n == ST_RUN);
      end
   end

   always_comb begin
      state_n     = state_q;
      mode_n      = mode_q;
      alarm_cnt_n = alarm_cnt;
      load_n      = 1'b0;
      acted       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (clear_rise) begin
               load_n = 1'b1;
               acted  = 1'b1;
            end else if (start_rise && !(!mode && all_zero)) begin
               state_n = ST_RUN;
               mode_n  = mode;
               acted   = 1'b1;
            end
         end
         ST_RUN: begin
            if (clear_rise) begin
               state_n = ST_IDLE;
               load_n  = 1'b1;
               acted   = 1'b1;
            end else if (pause_rise) begin
               state_n = ST_PAUSE;
               acted   = 1'b1;
            end else if (end_hit) begin
               state_n     = ST_DONE;
               alarm_cnt_n = 8'd0;
            end
         end
         ST_PAUSE: begin
            if (clear_rise) begin
               state_n = ST_IDLE;
               load_n  = 1'b1;
               acted   = 1'b1;
            end else if (start_rise || pause_rise) begin
               state_n = ST_RUN;
               acted   = 1'b1;
            end
         end
         ST_DONE: begin
            if (clear_rise) begin
               state_n = ST_IDLE;
               load_n  = 1'b1;
               acted   = 1'b1;
            end else if (start_rise || pause_rise) begin
               state_n = ST_IDLE;
               acted   = 1'b1;
            end else if (tick_1hz) begin
               if (alarm_cnt == LAST_CNT) state_n = ST_IDLE;
               else alarm_cnt_n = alarm_cnt + 8'd1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Ripple condition per lower digit: all-zero for borrow, all-max for carry.
   always_comb begin
      low_ok[0] = mode_q ? (digits[3:0] == 4'd9)    : (digits[3:0] == 4'd0);
      low_ok[1] = mode_q ? (digits[7:4] == SEC_MAX) : (digits[7:4] == 4'd0);
      low_ok[2] = mode_q ? (digits[11:8] == 4'd9)   : (digits[11:8] == 4'd0);
      digit_en  = 4'b0000;
      if (state_q == ST_RUN && tick_1hz && !end_hit && !acted) begin
         digit_en[0] = 1'b1;
         digit_en[1] = low_ok[0];
         digit_en[2] = low_ok[0] & low_ok[1];
         digit_en[3] = low_ok[0] & low_ok[1] & low_ok[2];
      end
   end

endmodule
